// File: rtl/ball_engine.sv
// Single-ball motion engine: serve delay, wall/paddle reflection with english
// and speed-up, miss detection, and a registered ball pixel for the mixer.
module ball_engine #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_Y      = 440,
  parameter int PADDLE_W      = 50,
  parameter int INIT_SPEED    = 1,
  parameter int MAX_SPEED     = 7,
  parameter int SPEEDUP       = 1,
  parameter int SERVE_UPDATES = 60,
  parameter int VW            = 5
) (
  input  logic       clck,
  input  logic       reset,
  input  logic [9:0] vgax,
  input  logic [8:0] vgay,
  input  logic       update,
  input  logic [9:0] paddleX,
  output logic       pixel,
  output logic       hit,
  output logic       miss,
  output logic       serving,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y
);

  localparam int SW = 12;
  localparam int CW = (SERVE_UPDATES > 1) ? $clog2(SERVE_UPDATES) : 1;

  localparam logic signed [SW-1:0] ZERO  = SW'(0);
  localparam logic signed [SW-1:0] ONE   = SW'(1);
  localparam logic signed [SW-1:0] BS    = SW'(BALL_SIZE);
  localparam logic signed [SW-1:0] XMAX  = SW'(SCREEN_W - BALL_SIZE);
  localparam logic signed [SW-1:0] YMAX  = SW'(SCREEN_H - BALL_SIZE);
  localparam logic signed [SW-1:0] PTOP  = SW'(PADDLE_Y - BALL_SIZE);
  localparam logic signed [SW-1:0] PWM1  = SW'(PADDLE_W - 1);
  localparam logic signed [SW-1:0] HALF  = SW'(BALL_SIZE / 2);
  localparam logic signed [SW-1:0] T1    = SW'(PADDLE_W / 3);
  localparam logic signed [SW-1:0] T2    = SW'(2 * (PADDLE_W / 3));
  localparam logic signed [SW-1:0] VMAX  = SW'(MAX_SPEED);
  localparam logic signed [SW-1:0] SPUP  = SW'(SPEEDUP);
  localparam logic signed [VW-1:0] VINIT = VW'(INIT_SPEED);
  localparam logic [9:0]           XC    = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [8:0]           YC    = 9'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [CW-1:0]        CLAST = CW'(SERVE_UPDATES - 1);

  typedef enum logic {SERVE, PLAY} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [9:0]           x, x_d;
  logic [8:0]           y, y_d;
  logic signed [VW-1:0] vx, vx_d, vy, vy_d;
  logic                 dir, dir_d;
  logic                 hit_d, miss_d, pix_d;

  logic signed [SW-1:0] sx, sy, svx, svy, px, nx, ny, xs_new, vx_w, vx_e, vy_m, off;
  logic [10:0]          x_end;
  logic [9:0]           y_end;

  always_ff @(posedge clck or negedge reset) begin
    if (!reset) begin
      state <= SERVE;
      cnt   <= '0;
      x     <= XC;
      y     <= YC;
      vx    <= VINIT;
      vy    <= VINIT;
      dir   <= 1'b1;
      hit   <= 1'b0;
      miss  <= 1'b0;
      pixel <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      x     <= x_d;
      y     <= y_d;
      vx    <= vx_d;
      vy    <= vy_d;
      dir   <= dir_d;
      hit   <= hit_d;
      miss  <= miss_d;
      pixel <= pix_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    x_d     = x;
    y_d     = y;
    vx_d    = vx;
    vy_d    = vy;
    dir_d   = dir;
    hit_d   = 1'b0;
    miss_d  = 1'b0;

    sx     = $signed(SW'(x));
    sy     = $signed(SW'(y));
    svx    = SW'(vx);
    svy    = SW'(vy);
    px     = $signed(SW'(paddleX));
    nx     = sx + svx;
    ny     = sy + svy;
    xs_new = sx;
    vx_w   = svx;
    vx_e   = svx;
    vy_m   = svy;
    off    = ZERO;

    if (update) begin
      case (state)
        SERVE: begin
          if (cnt == CLAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        PLAY: begin
          if (nx <= ZERO) begin
            xs_new = ZERO;
            vx_w   = ZERO - svx;
          end else if (nx >= XMAX) begin
            xs_new = XMAX;
            vx_w   = ZERO - svx;
          end else begin
            xs_new = nx;
          end
          x_d  = xs_new[9:0];
          vx_d = VW'(vx_w);

          if (ny <= ZERO) begin
            y_d  = '0;
            vy_d = VW'(ZERO - svy);
          end else if (svy > ZERO && ny >= PTOP && sy < PTOP &&
                       xs_new + BS >= px && xs_new <= px + PWM1) begin
            y_d  = PTOP[8:0];
            vy_m = svy + SPUP;
            if (vy_m > VMAX) vy_m = VMAX;
            vy_d = VW'(ZERO - vy_m);
            // English steers from the post-wall velocity, so a corner bounce
            // still gets its reflected sign as the zero-avoidance fallback.
            off  = xs_new + HALF - px;
            vx_e = vx_w;
            if (off < T1)       vx_e = vx_w - ONE;
            else if (off >= T2) vx_e = vx_w + ONE;
            if (vx_e > VMAX)             vx_e = VMAX;
            else if (vx_e < ZERO - VMAX) vx_e = ZERO - VMAX;
            if (vx_e == ZERO) vx_e = (vx_w < ZERO) ? ZERO - ONE : ONE;
            vx_d  = VW'(vx_e);
            hit_d = 1'b1;
          end else if (ny >= YMAX) begin
            miss_d  = 1'b1;
            state_d = SERVE;
            cnt_d   = '0;
            x_d     = XC;
            y_d     = YC;
            vx_d    = dir ? -VINIT : VINIT;
            dir_d   = ~dir;
            vy_d    = VINIT;
          end else begin
            y_d = ny[8:0];
          end
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_comb begin
    x_end = {1'b0, x} + 11'(BALL_SIZE - 1);
    y_end = {1'b0, y} + 10'(BALL_SIZE - 1);
    pix_d = (vgax >= x) && ({1'b0, vgax} <= x_end) &&
            (vgay >= y) && ({1'b0, vgay} <= y_end);
  end

  assign serving = (state == SERVE);
  assign ball_x  = x;
  assign ball_y  = y;

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Parametrised successor to the single-ball motion block in the VGA paddle game.
- Owns the ball position and signed velocity, wall reflection and paddle collision with english (hit-position steering) and speed-up.
- Detects a miss at the bottom edge and runs a serve delay after reset and after every miss.
- Produces the registered ball pixel for the video mixer, plus hit/miss event pulses for scoring and sound logic.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- BALL_SIZE, 10, ball edge length in pixels.
- PADDLE_Y, 440, top row of the paddle.
- PADDLE_W, 50, paddle width in pixels.
- INIT_SPEED, 1, magnitude of |vx| and |vy| at serve.
- MAX_SPEED, 7, ceiling on |vx| and |vy|.
- SPEEDUP, 1, 1 = add 1 to |vy| on each paddle hit.
- SERVE_UPDATES, 60, number of update pulses the ball rests at centre before moving.
- VW, 5, signed velocity width; must hold ±MAX_SPEED.

Ports:
- clck  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- vgax  in  10  current scan column.
- vgay  in  9  current scan row.
- update  in  1  one-cycle pulse, once per frame; motion advances only on this pulse.
- paddleX  in  10  left column of the paddle.
- pixel  out  1  registered ball coverage for (vgax, vgay).
- hit  out  1  one-cycle pulse on a paddle bounce.
- miss  out  1  one-cycle pulse when the ball reaches the bottom.
- serving  out  1  high while in SERVE.
- ball_x  out  10  current ball left column.
- ball_y  out  9  current ball top row.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - x = SCREEN_W/2 - BALL_SIZE/2 (315); y = SCREEN_H/2 - BALL_SIZE/2 (235).
  - vx = +INIT_SPEED, vy = +INIT_SPEED.
  - state = SERVE, serve counter = 0.
  - pixel = hit = miss = 0, serving = 1.
  - next-serve direction flag = negative.
- Reset may arrive at any time, including mid-update; the release cycle behaves as a plain idle cycle.
- All state changes occur only on cycles where update=1; in all other cycles the state holds.
- SERVE:
  - Each update increments the serve counter.
  - When the counter equals SERVE_UPDATES-1 on an update, go to PLAY and clear the counter. No motion occurs on that update.
- PLAY, per update, using signed arithmetic wide enough for no overflow:
  - Compute nx = x+vx and ny = y+vy.
  - Left wall: if nx <= 0, set x = 0 and vx = -vx.
  - Right wall: if nx >= SCREEN_W-BALL_SIZE, set x = SCREEN_W-BALL_SIZE and vx = -vx.
  - Otherwise x = nx.
  - Top wall: if ny <= 0, set y = 0 and vy = -vy.
  - Paddle: if vy > 0, ny >= PADDLE_Y-BALL_SIZE, y < PADDLE_Y-BALL_SIZE, and the clamped new x overlaps the paddle (x+BALL_SIZE >= paddleX and x <= paddleX+PADDLE_W-1):
    - y = PADDLE_Y-BALL_SIZE; vy = -(vy + SPEEDUP), with magnitude clamped to MAX_SPEED.
    - Compute offset = x + BALL_SIZE/2 - paddleX, where T = PADDLE_W/3 (integer division).
    - If offset < T, vx -= 1; if offset >= 2T, vx += 1. Clamp vx to ±MAX_SPEED.
    - If vx becomes 0, set it to the sign of the previous vx times 1.
    - Pulse hit.
  - Miss: else if ny >= SCREEN_H-BALL_SIZE:
    - Pulse miss.
    - Reload centre position and go to SERVE.
    - vx = ±INIT_SPEED using the direction flag, then toggle the flag; vy = +INIT_SPEED.
  - Otherwise y = ny.
  - Simultaneous corner events: x and y handling are independent. Paddle takes priority over miss.
- Pixel: registered, 1-cycle latency, drawn in both states.
  - pixel = (x <= vgax <= x+BALL_SIZE-1) and (y <= vgay <= y+BALL_SIZE-1). The box is exactly BALL_SIZE wide.
- Outputs hit, miss, ball_x, ball_y and serving are registered and update in the same cycle as the state they report.
- paddleX is sampled only on update cycles.

Test Plan:
- Reset and pixel:
  - Deassert reset, hold update=0. Require ball_x=315, ball_y=235, serving=1.
  - Drive (vgax,vgay)=(315,235) → pixel=1 one cycle later.
  - (324,244) → 1; (325,235) → 0; (315,245) → 0.
- Serve delay:
  - Issue 59 updates → serving=1, position 315/235.
  - 60th update → serving=0, position unchanged.
  - 61st update → ball_x=316, ball_y=236.
- Paddle hit with english:
  - paddleX=480. After serve, issue 195 PLAY updates → ball_x=510, ball_y=430.
  - On that update: hit=1 for one cycle, vx=+2, vy=-2.
  - Next update → ball_x=512, ball_y=428.
- Right-wall clamp:
  - Continue from the hit scenario for 60 more updates → ball_x=630, ball_y=310, vx=-2.
  - Next update → ball_x=628.
- Miss and alternating serve:
  - paddleX=0. After 235 PLAY updates (y reaches 470): miss=1 for one cycle, serving=1, position 315/235.
  - After the next serve, the first move → ball_x=314, ball_y=236.
- Asynchronous reset mid-PLAY:
  - Assert reset between clock edges during motion. Outputs go to reset values immediately, with no clock edge.
  - After release, a full 60-update serve occurs.
